clk_div: RTL and testbench
==========================

# clk_div

Integer clock divider that consumes the 8-bit division ratio produced by the prescaler-to-ratio mux and generates the divided clock for the UART baud domain. The ratio is captured into a shadow register only at period boundaries, so the divided clock never produces short high or low phases inside the active path when the ratio changes. Ratios 0 and 1, or a deasserted enable, bypass the divider and pass the reference clock through unchanged.

## Interface
- RATIO_WD, 8, width of the ratio input, the shadow register and the phase counter.
- i_ref_clk  in  1  reference clock. All logic is clocked on its rising edge.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_clk_en  in  1  divider enable. Low forces bypass.
- i_div_ratio  in  RATIO_WD  requested division ratio N, unsigned.
- o_div_clk  out  1  divided clock. In bypass it equals i_ref_clk.

## Operation
- Internal state:
  - ratio_q: shadow ratio, RATIO_WD bits.
  - cnt: phase counter, RATIO_WD bits.
  - div_q: divided clock register.
- Derived values: hi = ratio_q >> 1; lo = ratio_q − hi.
  - Even N: hi = lo = N/2.
  - Odd N: the high phase is one cycle shorter, hi = (N−1)/2 and lo = (N+1)/2.
  - Period = N reference cycles exactly.
- active = i_clk_en && (ratio_q >= 2).
- o_div_clk = active ? div_q : i_ref_clk. This is a combinational output mux.
- Reset (i_rst_n = 0):
  - ratio_q = 1, cnt = 0, div_q = 0.
  - The block is therefore in bypass and o_div_clk follows i_ref_clk.
- When not active, every edge: cnt <= 0, div_q <= 0, ratio_q <= i_div_ratio. The ratio is tracked continuously.
- When active, every edge:
  - div_q = 0 and cnt = lo−1: div_q <= 1, cnt <= 0, ratio_q <= i_div_ratio. This is the period boundary and the only point where a new ratio is captured.
  - div_q = 1 and cnt = hi−1: div_q <= 0, cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
- Two-state machine on div_q:
  - LOW state: lo cycles, then go to HIGH.
  - HIGH state: hi cycles, then go to LOW.
  - After entering active, the first phase is always LOW.
- A ratio captured at the boundary that is < 2 drops the block to bypass on the next cycle.
- cnt never exceeds lo−1 ≤ 127 for RATIO_WD = 8, so no counter overflow is possible.

## Timing
- Bypass to divide: the cycle after ratio_q loads N ≥ 2 with enable high, o_div_clk switches from i_ref_clk to div_q = 0.
  - The first rising edge of o_div_clk occurs lo edges later.
- A change of i_div_ratio while active has no effect until the next rising edge of o_div_clk.
  - The new ratio governs the high phase that starts there.
- Enable handling:
  - i_clk_en falling: bypass takes effect combinationally in the same cycle, and the state clears on the next edge.
  - i_clk_en rising: the divide path restarts from LOW with cnt = 0.
- Reset asserted mid-period: state clears immediately (asynchronously) and the output goes to bypass.
- Simultaneous enable drop and boundary: the enable wins. The state is cleared and ratio_q takes i_div_ratio.
- Upstream ratios 1/2/4/8 yield:
  - bypass for 1;
  - 1/1 for 2;
  - 2/2 for 4;
  - 4/4 for 8 (high/low cycles).

## Test plan
- Reset release, ratio 1, enable 1 → o_div_clk identical to i_ref_clk for 20 cycles. Ratio 0 → same.
- Ratio 8, enable 1 from reset → first rise 4 edges after entering active, then a steady 4-high/4-low pattern with period 8 over 10 periods.
- Ratio 3 → 1 cycle high, 2 cycles low, period 3. Ratio 255 → 127 high, 128 low.
- Ratio 8 running, change to 2 mid-high-phase → current 4/4 period completes, then 1/1 from the next rising edge. No phase shorter than the old or new half-period.
- Ratio 4 running, enable dropped mid-LOW for 3 cycles then raised → bypass during the drop. Restart with a 2-cycle LOW, then 2 HIGH.
- Ratio 8, reset asserted mid-HIGH → o_div_clk immediately follows i_ref_clk. After release, the pattern restarts from LOW with a 4-cycle first phase.

Source files
------------

// File: rtl/clk_div_if.sv
// Ratio/enable inputs and divided-clock output of the UART baud clock divider.
interface clk_div_if #(
  parameter int unsigned RATIO_WD = 8
);
  logic                i_clk_en;
  logic [RATIO_WD-1:0] i_div_ratio;
  logic                o_div_clk;

  modport master (output i_clk_en, output i_div_ratio, input o_div_clk);
  modport slave  (input i_clk_en, input i_div_ratio, output o_div_clk);
endinterface

// File: rtl/clk_div.sv
// Integer clock divider with a ratio shadow register reloaded only at the LOW->HIGH boundary;
// ratios below 2 or a low enable pass the reference clock straight through.
module clk_div #(
  parameter int unsigned RATIO_WD = 8
) (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  clk_div_if.slave   if_div
);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  state_t              r_state;
  logic [RATIO_WD-1:0] r_ratio;
  logic [RATIO_WD-1:0] r_cnt;

  logic [RATIO_WD-1:0] w_hi;
  logic [RATIO_WD-1:0] w_lo;
  logic [RATIO_WD-1:0] w_hi_last;
  logic [RATIO_WD-1:0] w_lo_last;
  logic                w_active;

  // Odd ratios give the extra cycle to the low phase.
  assign w_hi      = r_ratio >> 1;
  assign w_lo      = r_ratio - w_hi;
  assign w_hi_last = w_hi - RATIO_WD'(1);
  assign w_lo_last = w_lo - RATIO_WD'(1);
  assign w_active  = if_div.i_clk_en && (r_ratio >= RATIO_WD'(2));

  assign if_div.o_div_clk = w_active ? (r_state == ST_HIGH) : i_ref_clk;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_ratio <= RATIO_WD'(1);
    end else if (!w_active) begin
      // Bypass: hold the divider at the start of a LOW phase and track the ratio.
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_ratio <= if_div.i_div_ratio;
    end else begin
      case (r_state)
        ST_LOW: begin
          if (r_cnt == w_lo_last) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
            r_ratio <= if_div.i_div_ratio;
          end else begin
            r_cnt <= r_cnt + RATIO_WD'(1);
          end
        end
        ST_HIGH: begin
          if (r_cnt == w_hi_last) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + RATIO_WD'(1);
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div.sv
// Scoreboard bench for clk_div: a phase-list model predicts every reference cycle and a
// monitor compares o_div_clk in both halves of each cycle.
module tb_clk_div;

  localparam int unsigned RATIO_WD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_div_if #(.RATIO_WD(RATIO_WD)) bus ();

  clk_div #(.RATIO_WD(RATIO_WD)) dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .if_div    (bus.slave)
  );

  typedef struct {
    int ratio;
    bit lvl;
  } exp_t;

  exp_t sb[$];
  exp_t cur = '{ratio: 1, lvl: 1'b0};
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: shadow ratio plus the list of levels still to be output.
  int m_ratio = 1;
  bit m_sched[$];

  function automatic int hi_len(int n);
    return n / 2;
  endfunction

  function automatic int lo_len(int n);
    return n - n / 2;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   p;
    if (!rst_n) begin
      m_ratio = 1;
      m_sched.delete();
    end else if (!(bus.i_clk_en && m_ratio >= 2)) begin
      m_ratio = int'(bus.i_div_ratio);
      m_sched.delete();
      for (int i = 0; i < lo_len(m_ratio); i++) m_sched.push_back(1'b0);
    end else begin
      p = (m_sched.size() > 0) ? m_sched.pop_front() : 1'b1;
      if (m_sched.size() == 0) begin
        if (!p) begin
          m_ratio = int'(bus.i_div_ratio);
          for (int i = 0; i < hi_len(m_ratio); i++) m_sched.push_back(1'b1);
        end else begin
          for (int i = 0; i < lo_len(m_ratio); i++) m_sched.push_back(1'b0);
        end
      end
    end
    e.ratio = m_ratio;
    e.lvl   = (m_sched.size() > 0) ? m_sched[0] : 1'b0;
    sb.push_back(e);
  end

  task automatic check_out(input string nm);
    bit exp_v;
    if (!rst_n || !(bus.i_clk_en && cur.ratio >= 2)) exp_v = clk;
    else                                             exp_v = cur.lvl;
    n_checks++;
    if (bus.o_div_clk === exp_v) n_pass++;
    else $display("FAIL %s t=%0t ratio=%0d en=%b got %b expected %b",
                  nm, $time, cur.ratio, bus.i_clk_en, bus.o_div_clk, exp_v);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty t=%0t got 0 entries expected 1", $time);
    end else begin
      cur = sb.pop_front();
      check_out("high_half");
    end
  end

  always @(negedge clk) begin
    #1;
    check_out("low_half");
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    run(n);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd1;
    run(3);
    rst_n = 1'b1;

    run(20);                        // ratio 1: bypass
    bus.i_div_ratio = 8'd0;
    run(20);                        // ratio 0: bypass

    do_reset(2);
    bus.i_div_ratio = 8'd8;
    run(85);

    bus.i_div_ratio = 8'd3;
    run(20);
    bus.i_div_ratio = 8'd255;
    run(600);

    // Ratio change in the middle of a high phase
    bus.i_div_ratio = 8'd8;
    run(20);
    k = 0;
    while (bus.o_div_clk !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) begin
      n_checks++;
      $display("FAIL wait_high got timeout expected high phase");
    end
    run(1);
    bus.i_div_ratio = 8'd2;
    run(30);

    // Enable drop mid-LOW for 3 cycles
    bus.i_div_ratio = 8'd4;
    run(13);
    bus.i_clk_en = 1'b0;
    run(3);
    bus.i_clk_en = 1'b1;
    run(16);

    // Reset mid-HIGH
    bus.i_div_ratio = 8'd8;
    run(12);
    k = 0;
    while (bus.o_div_clk !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) begin
      n_checks++;
      $display("FAIL wait_high2 got timeout expected high phase");
    end
    run(1);
    do_reset(2);
    run(30);

    // Randomized ratio/enable/reset traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 5))
        0:       bus.i_div_ratio = 8'($urandom_range(0, 1));
        1:       bus.i_div_ratio = 8'd2;
        2:       bus.i_div_ratio = 8'($urandom_range(3, 20));
        3:       bus.i_div_ratio = 8'd255;
        4:       bus.i_div_ratio = 8'($urandom_range(0, 255));
        default: bus.i_div_ratio = 8'd4;
      endcase
      bus.i_clk_en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 29) == 0) do_reset(1);
      run(int'($urandom_range(1, 40)));
    end

    run(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
